// File: rtl/trb_pkt_dispatch.sv
// Ready-aware round-robin dispatcher: one bus stream to NUM_CH decoder lanes, one whole packet per grant.
// Latency 1 cycle in->out; in_ready follows the granted lane's ch_ready, so a stalled lane stalls the stream.
module trb_pkt_dispatch #(
  parameter int BUS       = 534,
  parameter int NUM_CH    = 2,
  parameter int PKT_WORDS = 25,
  parameter int CNT_W     = 16,
  localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WCW      = $clog2(PKT_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS-1:0]    in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [BUS-1:0]    out_data,
  output logic [NUM_CH-1:0] out_en,
  output logic              out_sop,
  output logic              out_eop,
  output logic [CHW-1:0]    cur_ch,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt
);

  typedef enum logic {ST_ARB, ST_XFER} state_t;

  state_t            state;
  logic [CHW-1:0]    ptr;
  logic [CHW-1:0]    nxt_ch;
  logic [WCW-1:0]    word_cnt;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] grant_oh;
  logic              found;
  logic              grant_rdy;
  logic              accept;
  logic              last_word;

  assign eligible = ch_ready & ch_mask;

  // Priority by distance from the last served lane: ptr+1 first, ptr itself last.
  always_comb begin
    found  = 1'b0;
    nxt_ch = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && eligible[j] && (j == (int'(ptr) + k) % NUM_CH)) begin
          found  = 1'b1;
          nxt_ch = CHW'(j);
        end
      end
    end
  end

  // cur_ch doubles as the grant register while in XFER.
  always_comb begin
    grant_oh  = '0;
    grant_rdy = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (CHW'(j) == cur_ch) begin
        grant_oh[j] = 1'b1;
        grant_rdy   = ch_ready[j];
      end
    end
  end

  assign in_ready  = (state == ST_XFER) && grant_rdy;
  assign accept    = in_valid && in_ready;
  assign last_word = (word_cnt == WCW'(PKT_WORDS - 1));
  assign busy      = (state == ST_XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ARB;
      ptr      <= CHW'(NUM_CH - 1);
      word_cnt <= '0;
      out_data <= '0;
      out_en   <= '0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      cur_ch   <= '0;
      pkt_cnt  <= '0;
    end else begin
      out_en  <= '0;
      out_sop <= 1'b0;
      out_eop <= 1'b0;
      case (state)
        ST_ARB: begin
          if (found) begin
            cur_ch <= nxt_ch;
            state  <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            out_data <= in_data;
            out_en   <= grant_oh;
            out_sop  <= (word_cnt == '0);
            out_eop  <= last_word;
            if (last_word) begin
              word_cnt <= '0;
              ptr      <= cur_ch;
              pkt_cnt  <= pkt_cnt + 1'b1;
              state    <= ST_ARB;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_trb_pkt_dispatch.sv
// Directed bench for trb_pkt_dispatch: a 2-lane/25-word instance and a 4-lane/3-word instance,
// outputs captured by negedge monitors and compared against hand-derived lane/framing/data sequences.
module tb_trb_pkt_dispatch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-lane, 25-word instance
  logic [533:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   ch_ready;
  logic [1:0]   ch_mask;
  logic [533:0] out_data;
  logic [1:0]   out_en;
  logic         out_sop;
  logic         out_eop;
  logic [0:0]   cur_ch;
  logic         busy;
  logic [15:0]  pkt_cnt;

  // 4-lane, 3-word instance
  logic [15:0]  d2;
  logic         v2;
  logic         r2;
  logic [3:0]   cr2;
  logic [3:0]   cm2;
  logic [15:0]  od2;
  logic [3:0]   oe2;
  logic         sop2;
  logic         eop2;
  logic [1:0]   cc2;
  logic         busy2;
  logic [7:0]   pc2;

  trb_pkt_dispatch dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ch_ready(ch_ready), .ch_mask(ch_mask), .out_data(out_data), .out_en(out_en),
    .out_sop(out_sop), .out_eop(out_eop), .cur_ch(cur_ch), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  trb_pkt_dispatch #(.BUS(16), .NUM_CH(4), .PKT_WORDS(3), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
    .ch_ready(cr2), .ch_mask(cm2), .out_data(od2), .out_en(oe2),
    .out_sop(sop2), .out_eop(eop2), .cur_ch(cc2), .busy(busy2), .pkt_cnt(pc2)
  );

  typedef struct {
    logic [3:0]  en;
    logic        sop;
    logic        eop;
    logic [15:0] dl;
    logic [15:0] dh;
    int          t;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  seq   = 0;

  function automatic logic [533:0] mk(input int v);
    logic [15:0] s;
    s = v[15:0];
    return {s, 502'd0, s};
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : mon1
    ev_t e;
    if (out_en !== 2'b00) begin
      e.en = {2'b00, out_en}; e.sop = out_sop; e.eop = out_eop;
      e.dl = out_data[15:0]; e.dh = out_data[533:518]; e.t = cyc;
      q1.push_back(e);
    end
  end

  always @(negedge clk) begin : mon2
    ev_t e;
    if (oe2 !== 4'b0000) begin
      e.en = oe2; e.sop = sop2; e.eop = eop2; e.dl = od2; e.dh = od2; e.t = cyc;
      q2.push_back(e);
    end
  end

  // Feeds nwords consecutive seq values into the 2-lane instance; optional in_valid gaps
  // and a ch_ready drop of drop_len cycles once drop_at words have been accepted.
  task automatic pump(input int nwords, input logic [1:0] rdy, input int gap_mod,
                      input int drop_at, input int drop_len);
    int acc, n, drop_left;
    acc = 0; n = 0; drop_left = 0;
    while (acc < nwords && n < 3000) begin
      @(negedge clk);
      n++;
      ch_ready = (drop_left > 0) ? 2'b00 : rdy;
      in_valid = (gap_mod == 0) || (n % gap_mod != 0);
      in_data  = mk(seq);
      #2;
      if (drop_left > 0) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_in_ready got=%b want=0", in_ready);
        end
        drop_left--;
      end
      if (in_valid && in_ready) begin
        seq++;
        acc++;
        if (acc == drop_at) drop_left = drop_len;
      end
    end
    total++;
    if (acc != nwords) begin
      bad++;
      $display("FAIL pump_timeout accepted=%0d want=%0d", acc, nwords);
    end
    @(negedge clk);
    in_valid = 1'b0;
    ch_ready = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_data = '0; in_valid = 1'b0; ch_ready = 2'b00; ch_mask = 2'b11;
    d2 = '0; v2 = 1'b0; cr2 = 4'b0000; cm2 = 4'b1111;
    repeat (3) @(negedge clk);
    total += 9;
    if (out_en !== 2'b00)   begin bad++; $display("FAIL rst_out_en got=%b want=00", out_en); end
    if (out_sop !== 1'b0)   begin bad++; $display("FAIL rst_sop got=%b want=0", out_sop); end
    if (out_eop !== 1'b0)   begin bad++; $display("FAIL rst_eop got=%b want=0", out_eop); end
    if (out_data !== '0)    begin bad++; $display("FAIL rst_out_data got=%h want=0", out_data[15:0]); end
    if (cur_ch !== 1'b0)    begin bad++; $display("FAIL rst_cur_ch got=%0d want=0", cur_ch); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (pkt_cnt !== 16'd0)  begin bad++; $display("FAIL rst_pkt_cnt got=%0d want=0", pkt_cnt); end
    if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    if (oe2 !== 4'b0000)    begin bad++; $display("FAIL rst_out_en4 got=%b want=0000", oe2); end
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int b, s0;
    logic [37:0] got, want;
    b = q1.size(); s0 = seq;
    pump(100, 2'b11, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q1.size() - b != 100) begin
      bad++; $display("FAIL rr_count got=%0d want=100", q1.size() - b);
    end else begin
      for (int i = 0; i < 100; i++) begin
        got  = {q1[b+i].en, q1[b+i].sop, q1[b+i].eop, q1[b+i].dl, q1[b+i].dh};
        want = {4'(1 << ((i / 25) % 2)), i % 25 == 0, i % 25 == 24, 16'(s0 + i), 16'(s0 + i)};
        total++;
        if (got !== want) begin bad++; $display("FAIL rr_word%0d got=%h want=%h", i, got, want); end
      end
      for (int i = 1; i < 100; i++) begin
        total++;
        if (q1[b+i].t - q1[b+i-1].t != ((i % 25 == 0) ? 2 : 1)) begin
          bad++;
          $display("FAIL rr_spacing%0d got=%0d want=%0d", i, q1[b+i].t - q1[b+i-1].t, (i % 25 == 0) ? 2 : 1);
        end
      end
    end
    total++;
    if (pkt_cnt !== 16'd4) begin bad++; $display("FAIL rr_pkt_cnt got=%0d want=4", pkt_cnt); end
  endtask

  task automatic test_busy_skip();
    int b, s0;
    logic [37:0] got, want;
    b = q1.size(); s0 = seq;
    pump(25, 2'b10, 0, 0, 0);
    pump(25, 2'b11, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q1.size() - b != 50) begin
      bad++; $display("FAIL skip_count got=%0d want=50", q1.size() - b);
    end else begin
      for (int i = 0; i < 50; i++) begin
        got  = {q1[b+i].en, q1[b+i].sop, q1[b+i].eop, q1[b+i].dl, q1[b+i].dh};
        want = {(i < 25) ? 4'b0010 : 4'b0001, i % 25 == 0, i % 25 == 24, 16'(s0 + i), 16'(s0 + i)};
        total++;
        if (got !== want) begin bad++; $display("FAIL skip_word%0d got=%h want=%h", i, got, want); end
      end
    end
    total += 2;
    if (pkt_cnt !== 16'd6) begin bad++; $display("FAIL skip_pkt_cnt got=%0d want=6", pkt_cnt); end
    if (cur_ch !== 1'b0)   begin bad++; $display("FAIL skip_cur_ch got=%0d want=0", cur_ch); end
  endtask

  task automatic test_mask();
    int b;
    b = q1.size();
    ch_mask = 2'b01;
    pump(50, 2'b11, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q1.size() - b != 50) begin
      bad++; $display("FAIL mask_count got=%0d want=50", q1.size() - b);
    end else begin
      for (int i = 0; i < 50; i += 5) begin
        total++;
        if (q1[b+i].en !== 4'b0001) begin bad++; $display("FAIL mask_lane%0d got=%b want=0001", i, q1[b+i].en); end
      end
    end
    total += 3;
    if (cur_ch !== 1'b0)   begin bad++; $display("FAIL mask_cur_ch got=%0d want=0", cur_ch); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL mask_idle_busy got=%b want=0", busy); end
    if (pkt_cnt !== 16'd8) begin bad++; $display("FAIL mask_pkt_cnt got=%0d want=8", pkt_cnt); end
    ch_mask = 2'b11;
  endtask

  task automatic test_stall();
    int b, s0;
    logic [37:0] got, want;
    b = q1.size(); s0 = seq;
    pump(25, 2'b11, 0, 11, 5);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q1.size() - b != 25) begin
      bad++; $display("FAIL stall_count got=%0d want=25", q1.size() - b);
    end else begin
      for (int i = 0; i < 25; i++) begin
        got  = {q1[b+i].en, q1[b+i].sop, q1[b+i].eop, q1[b+i].dl, q1[b+i].dh};
        want = {4'b0010, i == 0, i == 24, 16'(s0 + i), 16'(s0 + i)};
        total++;
        if (got !== want) begin bad++; $display("FAIL stall_word%0d got=%h want=%h", i, got, want); end
      end
      total++;
      if (q1[b+11].t - q1[b+10].t != 6) begin
        bad++; $display("FAIL stall_gap got=%0d want=6", q1[b+11].t - q1[b+10].t);
      end
    end
    total++;
    if (pkt_cnt !== 16'd9) begin bad++; $display("FAIL stall_pkt_cnt got=%0d want=9", pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int b, s0;
    logic [37:0] got, want;
    s0 = seq;
    pump(12, 2'b11, 0, 0, 0);
    #1;
    total += 2;
    if (out_en !== 2'b01 || out_data[15:0] !== 16'(s0 + 11)) begin
      bad++; $display("FAIL rmid_pre got=%b/%h want=01/%h", out_en, out_data[15:0], 16'(s0 + 11));
    end
    if (busy !== 1'b1) begin bad++; $display("FAIL rmid_pre_busy got=%b want=1", busy); end
    #1 rst = 1'b1;
    #1;
    total += 7;
    if (out_en !== 2'b00)  begin bad++; $display("FAIL rmid_out_en got=%b want=00", out_en); end
    if (out_sop !== 1'b0 || out_eop !== 1'b0) begin bad++; $display("FAIL rmid_sopeop got=%b%b want=00", out_sop, out_eop); end
    if (out_data !== '0)   begin bad++; $display("FAIL rmid_out_data got=%h want=0", out_data[15:0]); end
    if (cur_ch !== 1'b0)   begin bad++; $display("FAIL rmid_cur_ch got=%0d want=0", cur_ch); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (pkt_cnt !== 16'd0) begin bad++; $display("FAIL rmid_pkt_cnt got=%0d want=0", pkt_cnt); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    b = q1.size(); s0 = seq;
    pump(25, 2'b11, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q1.size() - b != 25) begin
      bad++; $display("FAIL rmid_count got=%0d want=25", q1.size() - b);
    end else begin
      for (int i = 0; i < 25; i++) begin
        got  = {q1[b+i].en, q1[b+i].sop, q1[b+i].eop, q1[b+i].dl, q1[b+i].dh};
        want = {4'b0001, i == 0, i == 24, 16'(s0 + i), 16'(s0 + i)};
        total++;
        if (got !== want) begin bad++; $display("FAIL rmid_word%0d got=%h want=%h", i, got, want); end
      end
    end
    total++;
    if (pkt_cnt !== 16'd1) begin bad++; $display("FAIL rmid_pkt_cnt_after got=%0d want=1", pkt_cnt); end
  endtask

  task automatic test_four_lane();
    int lanes[6] = '{0, 1, 3, 0, 1, 3};
    int b, acc, n, s;
    logic [37:0] got, want;
    b = q2.size(); acc = 0; n = 0; s = 100;
    while (acc < 18 && n < 500) begin
      @(negedge clk);
      n++;
      cr2 = 4'b1011;
      v2  = (n % 3 != 0);
      d2  = 16'(s);
      #2;
      if (v2 && r2) begin s++; acc++; end
    end
    total++;
    if (acc != 18) begin bad++; $display("FAIL four_timeout accepted=%0d want=18", acc); end
    @(negedge clk);
    v2 = 1'b0; cr2 = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (q2.size() - b != 18) begin
      bad++; $display("FAIL four_count got=%0d want=18", q2.size() - b);
    end else begin
      for (int i = 0; i < 18; i++) begin
        got  = {q2[b+i].en, q2[b+i].sop, q2[b+i].eop, q2[b+i].dl, q2[b+i].dh};
        want = {4'(1 << lanes[i / 3]), i % 3 == 0, i % 3 == 2, 16'(100 + i), 16'(100 + i)};
        total++;
        if (got !== want) begin bad++; $display("FAIL four_word%0d got=%h want=%h", i, got, want); end
      end
    end
    total += 2;
    if (pc2 !== 8'd6)  begin bad++; $display("FAIL four_pkt_cnt got=%0d want=6", pc2); end
    if (cc2 !== 2'd3)  begin bad++; $display("FAIL four_cur_ch got=%0d want=3", cc2); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_busy_skip();
    test_mask();
    test_stall();
    test_reset_mid();
    test_four_lane();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
